// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V ISA definitions for the instruction encoder and its helpers.
// Contents: instruction format codes, opcode constants, error codes,
// the encoder request payload struct and the 12-bit immediate fit check.
package riscv_isa_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // Format is selected by opcode[6:5].
  typedef enum logic [1:0] {
    FMT_I     = 2'b00,
    FMT_S     = 2'b01,
    FMT_UNSUP = 2'b10,
    FMT_SB    = 2'b11
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_FMT   = 2'b10
  } err_e;

  // Decoded instruction fields as presented to the encoder.
  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
  } instr_req_t;

  // True when imm is a sign extension of its low 12 bits.
  function automatic logic imm12_fits(input logic [XLEN-1:0] imm);
    return (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: instruction fields + immediate -> 32-bit word.
// Ports:
//   req      in   decoded fields and 64-bit immediate (SB in halfword units)
//   word     out  packed I/S/SB instruction word (zero for unsupported format)
//   fmt      out  format selected by opcode[6:5]
//   range_ok out  immediate fits in a signed 12-bit field
module instr_field_pack
  import riscv_isa_pkg::*;
(
  input  instr_req_t        req,
  output logic [ILEN-1:0]   word,
  output fmt_e              fmt,
  output logic              range_ok
);

  always_comb begin
    fmt      = fmt_e'(req.opcode[6:5]);
    range_ok = imm12_fits(req.imm);
    word     = '0;
    case (fmt)
      FMT_I:  word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S:  word = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                      req.imm[4:0], req.opcode};
      // Immediate is already in halfword units, so bit 0 is a real offset bit.
      FMT_SB: word = {req.imm[11], req.imm[9:4], req.rs2, req.rs1, req.funct3,
                      req.imm[3:0], req.imm[10], req.opcode};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RISC-V instruction encoder: packs decoded fields into I/S/SB
// words and streams them with sequential byte addresses to a memory loader.
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN (reject immediates
// that do not fit in 12 signed bits; otherwise they are truncated).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   flush                  synchronous restart (drop word, address to BASE_ADDR)
//   in_valid/in_ready      request handshake; in_* carry the decoded fields
//   out_valid/out_ready    word handshake; out_instr/out_addr carry the word
//   err_valid/err_code     one-cycle rejection pulse and reason
//   err_count              saturating count of rejected requests
module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ILEN-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ILEN-1:0]   out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_valid_q, err_valid_d;
  err_e              err_code_q, err_code_d;
  logic [15:0]       err_count_q, err_count_d;

  instr_req_t      req;
  logic [ILEN-1:0] pack_word;
  fmt_e            pack_fmt;
  logic            pack_range_ok;
  logic            imm_ok;
  logic            accept, good, reject;
  err_e            reject_code;

  assign req = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                 funct3: in_funct3, imm: in_imm};

  instr_field_pack u_pack (
    .req      (req),
    .word     (pack_word),
    .fmt      (pack_fmt),
    .range_ok (pack_range_ok)
  );

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign imm_ok = pack_range_ok;
`else
  // Without the range check the packer simply keeps imm[11:0].
  logic unused_range_ok;
  assign unused_range_ok = pack_range_ok;
  assign imm_ok          = 1'b1;
`endif

  // Request handshake and classification; flush blocks acceptance.
  assign in_ready    = !flush && (state_q == EMPTY || out_ready);
  assign accept      = in_valid && in_ready;
  assign good        = accept && (pack_fmt != FMT_UNSUP) && imm_ok;
  assign reject      = accept && !good;
  // Unsupported format takes precedence over a range violation.
  assign reject_code = (pack_fmt == FMT_UNSUP) ? ERR_FMT : ERR_RANGE;

  // Next-state: word holding register, address counter and error reporting.
  always_comb begin
    state_d     = state_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    err_valid_d = reject;
    err_code_d  = reject ? reject_code : ERR_NONE;
    err_count_d = err_count_q;

    if (reject && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end

    if (flush) begin
      state_d     = EMPTY;
      next_addr_d = BASE_ADDR;
    end else if (good) begin
      // A new word may replace a draining one on the same edge.
      state_d     = FULL;
      out_instr_d = pack_word;
      out_addr_d  = next_addr_q;
      next_addr_d = next_addr_q + ADDR_W'(4);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed format/handshake/error
// scenarios plus a randomized run against a word-level scoreboard.
// Honors INSTR_ENCODER_RANGE_CHECK_EN to select the expected error behavior.
module tb_instr_encoder;
  import riscv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] err_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_next = 64'd0;
  logic [15:0] exp_errcnt = 16'd0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(64), .BASE_ADDR(64'd0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
  );

  // Reference encoder built from the bit positions with shifts and masks.
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [63:0] imm);
    logic [63:0] w;
    w = 64'(op) | (64'(f3) << 12) | (64'(rs1) << 15);
    case (op[6:5])
      2'b00: w = w | (64'(rd) << 7) | ((imm & 64'hFFF) << 20);
      2'b01: w = w | (64'(rs2) << 20) | ((imm & 64'h1F) << 7)
                   | (((imm >> 5) & 64'h7F) << 25);
      2'b11: w = w | (64'(rs2) << 20) | (((imm >> 11) & 64'd1) << 31)
                   | (((imm >> 4) & 64'h3F) << 25) | ((imm & 64'hF) << 8)
                   | (((imm >> 10) & 64'd1) << 7);
      default: w = 64'd0;
    endcase
    return w[31:0];
  endfunction

  // Reference decoder: recovers the immediate in the decoder's convention.
  function automatic logic [63:0] dec_imm(input logic [31:0] w);
    logic [11:0] f;
    case (w[6:5])
      2'b00:   f = w[31:20];
      2'b01:   f = {w[31:25], w[11:7]};
      default: f = {w[31], w[7], w[30:25], w[11:8]};
    endcase
    return {{52{f[11]}}, f};
  endfunction

  function automatic logic fits12(input logic [63:0] imm);
    longint s;
    s = longint'(imm);
    return (s >= -2048) && (s <= 2047);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [63:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    #7;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset out_instr: got %h want 0", out_instr); end
    n_checks++; if (out_addr !== 64'd0) begin n_fail++; $display("FAIL reset out_addr: got %h want 0", out_addr); end
    n_checks++; if (err_valid !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL reset err: got %b/%b want 0/00", err_valid, err_code); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  // I, S, SB words from the worked examples, issued back to back.
  task automatic test_formats();
    logic [6:0]  ops  [3] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH};
    logic [4:0]  rds  [3] = '{5'd5, 5'd0, 5'd0};
    logic [4:0]  rs1s [3] = '{5'd2, 5'd2, 5'd1};
    logic [4:0]  rs2s [3] = '{5'd0, 5'd10, 5'd2};
    logic [2:0]  f3s  [3] = '{3'd3, 3'd3, 3'd0};
    logic [63:0] imms [3] = '{-64'sd8, 64'd16, -64'sd2};
    logic [31:0] want [3] = '{32'hFF813283, 32'h00A13823, 32'hFE208EE3};
    for (int i = 0; i < 3; i++) begin
      set_req(ops[i], rds[i], rs1s[i], rs2s[i], f3s[i], imms[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fmt%0d in_ready: got %b want 1", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fmt%0d out_valid: got %b want 1", i, out_valid); end
      n_checks++; if (out_instr !== want[i]) begin n_fail++; $display("FAIL fmt%0d instr: got %h want %h", i, out_instr, want[i]); end
      n_checks++; if (out_instr !== enc(ops[i], rds[i], rs1s[i], rs2s[i], f3s[i], imms[i])) begin n_fail++; $display("FAIL fmt%0d model instr: got %h", i, out_instr); end
      n_checks++; if (out_addr !== exp_next) begin n_fail++; $display("FAIL fmt%0d addr: got %h want %h", i, out_addr, exp_next); end
      n_checks++; if (dec_imm(out_instr) !== imms[i]) begin n_fail++; $display("FAIL fmt%0d roundtrip: got %h want %h", i, dec_imm(out_instr), imms[i]); end
      exp_next += 64'd4;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt drain out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wa, wb;
    logic [63:0] aa;
    wa = enc(OPC_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 64'd100);
    wb = enc(OPC_LOAD, 5'd7, 5'd8, 5'd0, 3'd1, -64'sd1);
    set_req(OPC_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 64'd100);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    aa = exp_next; exp_next += 64'd4;
    set_req(OPC_LOAD, 5'd7, 5'd8, 5'd0, 3'd1, -64'sd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d in_ready: got %b want 0", k, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_instr !== wa || out_addr !== aa) begin n_fail++; $display("FAIL bp%0d hold: got %b %h %h want 1 %h %h", k, out_valid, out_instr, out_addr, wa, aa); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_instr !== wb || out_addr !== aa + 64'd4) begin n_fail++; $display("FAIL bp second word: got %b %h %h want 1 %h %h", out_valid, out_instr, out_addr, wb, aa + 64'd4); end
    exp_next += 64'd4;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp drain: got %b want 0", out_valid); end
  endtask

  task automatic test_range();
    set_req(OPC_LOAD, 5'd1, 5'd1, 5'd0, 3'd0, 64'd2048);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    exp_errcnt += 16'd1;
    n_checks++; if (err_valid !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL range err: got %b/%b want 1/01", err_valid, err_code); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL range out_valid: got %b want 0", out_valid); end
`else
    n_checks++; if (out_valid !== 1'b1 || out_instr[31:20] !== 12'h800 || out_addr !== exp_next) begin n_fail++; $display("FAIL range trunc: got %b %h %h want imm 800 at %h", out_valid, out_instr, out_addr, exp_next); end
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL range no err: got %b want 0", err_valid); end
    exp_next += 64'd4;
`endif
    n_checks++; if (err_count !== exp_errcnt) begin n_fail++; $display("FAIL range count: got %0d want %0d", err_count, exp_errcnt); end
    tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL range pulse width: got %b want 0", err_valid); end
    // Unsupported format rejected in both builds.
    set_req(7'b1010011, 5'd1, 5'd2, 5'd3, 3'd0, 64'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_errcnt += 16'd1;
    n_checks++; if (err_valid !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL fmt err: got %b/%b want 1/10", err_valid, err_code); end
    n_checks++; if (err_count !== exp_errcnt || out_valid !== 1'b0) begin n_fail++; $display("FAIL fmt err count/valid: got %0d/%b want %0d/0", err_count, out_valid, exp_errcnt); end
    tick();
    // Good word reuses the address not consumed by the rejects.
    set_req(OPC_LOAD, 5'd3, 5'd4, 5'd0, 3'd2, 64'd7);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_addr !== exp_next) begin n_fail++; $display("FAIL range next addr: got %b %h want 1 %h", out_valid, out_addr, exp_next); end
    exp_next += 64'd4;
    // Reject while FULL with out_ready: held word still drains.
    set_req(7'b1000000, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_errcnt += 16'd1;
    n_checks++; if (out_valid !== 1'b0 || err_valid !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL reject+drain: got %b %b %b want 0 1 10", out_valid, err_valid, err_code); end
    tick();
  endtask

  task automatic test_flush_reset();
    set_req(OPC_STORE, 5'd0, 5'd5, 5'd6, 3'd1, 64'd12);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    exp_next += 64'd4;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush pre out_valid: got %b want 1", out_valid); end
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_next = 64'd0;
    n_checks++; if (out_valid !== 1'b0 || err_count !== exp_errcnt) begin n_fail++; $display("FAIL flush state: got %b/%0d want 0/%0d", out_valid, err_count, exp_errcnt); end
    set_req(OPC_LOAD, 5'd9, 5'd10, 5'd0, 3'd0, 64'd33);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 64'd0) begin n_fail++; $display("FAIL flush base addr: got %b %h want 1 0", out_valid, out_addr); end
    #2;
    reset = 1'b1;
    #1;
    exp_next = 64'd0; exp_errcnt = 16'd0;
    n_checks++; if (out_valid !== 1'b0 || out_addr !== 64'd0 || out_instr !== 32'd0) begin n_fail++; $display("FAIL async reset: got %b %h %h want 0 0 0", out_valid, out_addr, out_instr); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 64'd0) begin n_fail++; $display("FAIL post reset addr: got %b %h want 1 0", out_valid, out_addr); end
    exp_next = 64'd4;
    tick();
  endtask

  // Random traffic against a one-entry scoreboard of the held word.
  task automatic test_random();
    logic        m_full = 1'b0, m_errv = 1'b0, m_rdy, fire;
    logic [1:0]  m_code = 2'b00, code;
    logic [31:0] m_word = 32'd0;
    logic [63:0] m_addr = 64'd0, imm;
    longint      si;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        si = longint'($urandom_range(0, 4095)) - 64'sd2048;
        imm = 64'(si);
      end else begin
        imm = {$urandom, $urandom};
      end
      set_req(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      m_rdy = !flush && (!m_full || out_ready);
      n_checks++; if (in_ready !== m_rdy) begin n_fail++; $display("FAIL rnd%0d in_ready: got %b want %b", c, in_ready, m_rdy); end
      n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rnd%0d out_valid: got %b want %b", c, out_valid, m_full); end
      if (m_full) begin
        n_checks++; if (out_instr !== m_word || out_addr !== m_addr) begin n_fail++; $display("FAIL rnd%0d word: got %h@%h want %h@%h", c, out_instr, out_addr, m_word, m_addr); end
      end
      n_checks++; if (err_valid !== m_errv || (m_errv && err_code !== m_code)) begin n_fail++; $display("FAIL rnd%0d err: got %b/%b want %b/%b", c, err_valid, err_code, m_errv, m_code); end
      n_checks++; if (err_count !== exp_errcnt) begin n_fail++; $display("FAIL rnd%0d err_count: got %0d want %0d", c, err_count, exp_errcnt); end
      fire = in_valid && m_rdy;
      code = 2'b00;
      if (in_opcode[6:5] == 2'b10) code = 2'b10;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      else if (!fits12(in_imm)) code = 2'b01;
`endif
      m_errv = 1'b0;
      if (flush) begin
        m_full = 1'b0; exp_next = 64'd0;
      end else if (fire && code != 2'b00) begin
        m_errv = 1'b1; m_code = code;
        if (exp_errcnt != 16'hFFFF) exp_errcnt += 16'd1;
        if (out_ready) m_full = 1'b0;
      end else if (fire) begin
        m_word = enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        m_addr = exp_next; exp_next += 64'd4; m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_range();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder: the write-side counterpart of the core's immediate decoder. Accepts decoded instruction fields plus a 64-bit immediate in the exact convention the decoder emits, packs them into a 32-bit I/S/SB word, and streams the words with sequential byte addresses to an instruction-memory loader. For every supported word, decode(encode(x)) == x. Used by the boot loader and the self-test program generator.

## Interface
- ADDR_W, 64, width of output address
- BASE_ADDR, 0, address of first emitted word and after flush
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous restart: drops held word, address back to BASE_ADDR
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_opcode  in  7  opcode; bits [6:5] select format
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3  funct3
- in_imm  in  64  immediate, sign-extended, decoder convention (SB in halfword units)
- out_valid  out  1  encoded word held
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  byte address of out_instr
- err_valid  out  1  one-cycle pulse, request rejected
- err_code  out  2  01 immediate out of range, 10 unsupported format
- err_count  out  16  saturating count of rejected requests

## Operation
- Format from in_opcode[6:5]: 00 I, 01 S, 11 SB, 10 unsupported (rejected).
- I: {imm[11:0], rs1, funct3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- SB: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
- Range rule: valid iff in_imm[63:11] all equal in_imm[11].
- Two states: EMPTY (out_valid=0), FULL (out_valid=1). in_ready = !flush & (EMPTY | out_ready).
- Good accept: load out_instr, out_addr <= next_addr, next_addr += 4 (wraps modulo 2^ADDR_W), go/stay FULL.
- Rejected accept: no word loaded, next_addr unchanged, err_valid=1 next cycle with err_code, err_count += 1 (sticks at 16'hFFFF). If FULL with out_ready, held word still drains that cycle.
- Out handshake without new good accept: FULL -> EMPTY.
- flush: out_valid <= 0, next_addr <= BASE_ADDR, err_count kept; request on the flush cycle is not accepted.
- Reset: out_valid 0, out_instr 0, out_addr BASE_ADDR, next_addr BASE_ADDR, err_valid 0, err_code 00, err_count 0.

## Timing
- Latency accept -> out_valid: 1 cycle. Error pulse: 1 cycle after rejected accept.
- Full throughput: one word/cycle while out_ready=1.
- out_instr/out_addr stable while out_valid & !out_ready.
- Simultaneous out handshake and good accept: new word replaces old in the same edge, out_valid stays 1.
- Reset mid-stream: held word discarded immediately (asynchronous).

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined: range rule enforced, violations rejected with err_code 01.
- Undefined: no range check, in_imm truncated to bits [11:0] and encoded; err_code 01 never produced. Format 10 rejection unaffected.

## Structure
- Shared package riscv_isa_pkg: FMT_I=2'b00, FMT_S=2'b01, FMT_SB=2'b11, opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011), ERR_RANGE/ERR_FMT codes.
- One combinational sub-module instr_field_pack: fields + imm -> 32-bit word, format, range_ok. Handshake, address counter, error logic in instr_encoder.

## Test plan
- I: opcode 0000011, rd=5, rs1=2, funct3=3, imm=-8 -> out_instr 0xFF813283, out_addr 0, one cycle after accept.
- S: opcode 0100011, rs1=2, rs2=10, funct3=3, imm=16 -> 0x00A13823, out_addr 4; feed to decoder, imm_data == 16.
- SB: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-2 -> 0xFE208EE3; decoder returns 64'hFFFF_FFFF_FFFF_FFFE.
- Backpressure: out_ready low 3 cycles with second request pending -> in_ready 0, out_instr/out_addr stable, second word at addr+4 after release.
- Range: I-type imm=2048 with macro -> err_valid pulse, err_code 01, err_count 1, no out_valid, next good word reuses address; without macro -> word with imm field 0x800. Opcode 1010011 -> err_code 10 in both builds.
- flush while FULL, then reset mid-stream -> out_valid 0, next word at BASE_ADDR; err_count survives flush, cleared by reset.
